// File: rtl/sample_rr_merger.sv
// Merges NUM_PORTS L/R sample streams into one tagged stream, with round-robin grants of BURST beats each.
// Latency: request to in_ready takes 1 cycle (arbitration), and in_ready to out_enable takes 1 cycle (registered output).
// Backpressure: in_ready follows out_ready combinationally; cycles stalled by out_ready alone do not advance the timeout.
module sample_rr_merger #(
    parameter int NUM_PORTS    = 4,
    parameter int SAMPLE_WIDTH = 24,
    parameter int BURST        = 2,
    parameter int TIMEOUT      = 256,
    parameter int CHAN_WIDTH   = $clog2(NUM_PORTS*BURST),
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BW = (BURST > 1)     ? $clog2(BURST)     : 1,
    localparam int TW = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_enable,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*SAMPLE_WIDTH-1:0] in_data,
    output logic                            out_enable,
    input  logic                            out_ready,
    output logic [SAMPLE_WIDTH-1:0]         out_data,
    output logic [CHAN_WIDTH-1:0]           out_chan,
    output logic                            sync_err,
    input  logic                            err_clear,
    output logic [PW-1:0]                   cur_port
);

    typedef enum logic {S_ARB, S_BURST} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           cur_port_q, cur_port_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    out_enable_q, out_enable_d;
    logic [SAMPLE_WIDTH-1:0] out_data_q, out_data_d;
    logic [CHAN_WIDTH-1:0]   out_chan_q, out_chan_d;
    logic                    sync_err_q, sync_err_d;

    logic                    found;
    logic [PW-1:0]           grant;
    logic [PW-1:0]           idx;
    logic [PW-1:0]           next_port;
    logic                    out_space;
    logic                    in_en_cur;
    logic                    accept;
    logic                    set_err;
    logic [SAMPLE_WIDTH-1:0] sel_data;
    logic [CHAN_WIDTH-1:0]   sel_chan;

    assign out_space = !out_enable_q || out_ready;
    assign in_en_cur = in_enable[cur_port_q];
    assign accept    = (state_q == S_BURST) && in_en_cur && out_space;
    assign sel_data  = in_data[cur_port_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign sel_chan  = CHAN_WIDTH'(int'(cur_port_q) * BURST + int'(beat_q));
    assign next_port = PW'((int'(cur_port_q) + 1) % NUM_PORTS);

    assign in_ready   = (state_q == S_BURST && out_space) ? (NUM_PORTS'(1) << cur_port_q) : '0;
    assign out_enable = out_enable_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign sync_err   = sync_err_q;
    assign cur_port   = cur_port_q;

    // Rotating priority scan: the first requester at or after ptr wins.
    always_comb begin
        found = 1'b0;
        grant = ptr_q;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_PORTS);
            if (!found && in_enable[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_port_d   = cur_port_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;
        out_enable_d = out_enable_q && !out_ready;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        set_err      = 1'b0;
        case (state_q)
            S_ARB: begin
                if (found) begin
                    cur_port_d = grant;
                    beat_d     = '0;
                    tmo_d      = '0;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                if (accept) begin
                    out_enable_d = 1'b1;
                    out_data_d   = sel_data;
                    out_chan_d   = sel_chan;
                    tmo_d        = '0;
                    if (beat_q == BW'(BURST-1)) begin
                        beat_d  = '0;
                        ptr_d   = next_port;
                        state_d = S_ARB;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (!in_en_cur) begin
                    // The source went quiet mid-frame: abandon the rest of the burst.
                    if (tmo_q == TW'(TIMEOUT-1)) begin
                        set_err = 1'b1;
                        tmo_d   = '0;
                        beat_d  = '0;
                        ptr_d   = next_port;
                        state_d = S_ARB;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = S_ARB;
        endcase
        sync_err_d = set_err ? 1'b1 : (err_clear ? 1'b0 : sync_err_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_ARB;
            ptr_q        <= '0;
            cur_port_q   <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
            out_enable_q <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_port_q   <= cur_port_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            out_enable_q <= out_enable_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            sync_err_q   <= sync_err_d;
        end
    end

endmodule
